// File: rtl/spi_slave_pkg.sv
// Shared types and helpers for the SPI slave timing blocks.
package spi_slave_pkg;

   typedef enum logic {
      ST_IDLE,
      ST_ACTIVE
   } ch_state_e;

   typedef struct packed {
      logic sig_ext;
      logic done;
      logic overrun;
   } ch_out_t;

   function automatic int unsigned clamp_len(input int unsigned len, input int unsigned max_len);
      return (len > max_len) ? max_len : len;
   endfunction

endpackage

// File: rtl/pulse_stretch_ch.sv
// One pulse-stretcher channel: edge/level trigger, length counter, done strobe
// and sticky overrun flag.
module pulse_stretch_ch
   import spi_slave_pkg::*;
#(
   parameter int MAX_CYCLES = 255,
   parameter int CNT_W      = $clog2(MAX_CYCLES + 1),
   parameter int RETRIGGER  = 1,
   parameter int EDGE_TRIG  = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             sig_in,
   input  logic [CNT_W-1:0] len_in,
   input  logic             clr_overrun,
   output ch_out_t          ch_out
);

   ch_state_e        state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             sig_prev_q, sig_prev_d;
   logic             sig_ext_q, sig_ext_d;
   logic             done_q, done_d;
   logic             overrun_q, overrun_d;

   logic             trig, len_nz, active, last, accept, drop;
   logic [CNT_W-1:0] len_eff;

   always_comb begin
      trig    = en & ((EDGE_TRIG != 0) ? (sig_in & ~sig_prev_q) : sig_in);
      len_eff = CNT_W'(clamp_len(32'(len_in), MAX_CYCLES));
      len_nz  = (len_eff != '0);
      active  = (state_q == ST_ACTIVE);
      last    = active & (cnt_q == CNT_W'(1));
      // The final active cycle always accepts, so back-to-back pulses join seamlessly.
      accept  = trig & len_nz & (~active | (RETRIGGER != 0) | last);
      drop    = trig & len_nz & active & ~accept;

      state_d    = state_q;
      cnt_d      = cnt_q;
      sig_ext_d  = 1'b0;
      done_d     = 1'b0;
      sig_prev_d = sig_in;
      overrun_d  = drop | (overrun_q & ~clr_overrun);

      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               state_d   = ST_ACTIVE;
               cnt_d     = len_eff;
               sig_ext_d = 1'b1;
            end
         end
         ST_ACTIVE: begin
            if (accept) begin
               cnt_d     = len_eff;
               sig_ext_d = 1'b1;
            end else if (last) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
               done_d  = 1'b1;
            end else begin
               cnt_d     = cnt_q - CNT_W'(1);
               sig_ext_d = 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         sig_prev_q <= 1'b0;
         sig_ext_q  <= 1'b0;
         done_q     <= 1'b0;
         overrun_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         sig_prev_q <= sig_prev_d;
         sig_ext_q  <= sig_ext_d;
         done_q     <= done_d;
         overrun_q  <= overrun_d;
      end
   end

   assign ch_out = '{sig_ext: sig_ext_q, done: done_q, overrun: overrun_q};

endmodule

// File: rtl/multi_channel_pulse_stretcher.sv
// CHANNELS independent pulse stretchers with run-time per-channel lengths.
module multi_channel_pulse_stretcher
   import spi_slave_pkg::*;
#(
   parameter int CHANNELS   = 4,
   parameter int MAX_CYCLES = 255,
   parameter int CNT_W      = $clog2(MAX_CYCLES + 1),
   parameter int RETRIGGER  = 1,
   parameter int EDGE_TRIG  = 1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      en,
   input  logic [CHANNELS-1:0]       sig_in,
   input  logic [CHANNELS*CNT_W-1:0] len_in,
   input  logic [CHANNELS-1:0]       clr_overrun,
   output logic [CHANNELS-1:0]       sig_ext,
   output logic [CHANNELS-1:0]       done,
   output logic [CHANNELS-1:0]       overrun
);

   ch_out_t ch_out [CHANNELS];

   for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      pulse_stretch_ch #(
         .MAX_CYCLES (MAX_CYCLES),
         .CNT_W      (CNT_W),
         .RETRIGGER  (RETRIGGER),
         .EDGE_TRIG  (EDGE_TRIG)
      ) u_ch (
         .clk         (clk),
         .rst         (rst),
         .en          (en),
         .sig_in      (sig_in[i]),
         .len_in      (len_in[i*CNT_W +: CNT_W]),
         .clr_overrun (clr_overrun[i]),
         .ch_out      (ch_out[i])
      );

      assign sig_ext[i] = ch_out[i].sig_ext;
      assign done[i]    = ch_out[i].done;
      assign overrun[i] = ch_out[i].overrun;
   end

endmodule

// File: tb/tb_multi_channel_pulse_stretcher.sv
// Scoreboard bench: five configurations share stimulus; a time-based model predicts outputs.
module tb_multi_channel_pulse_stretcher;

   localparam int NC = 5;
   localparam int CR [NC] = '{1, 0, 1, 0, 1};
   localparam int CE [NC] = '{1, 1, 0, 0, 1};
   localparam int CM [NC] = '{255, 255, 255, 255, 200};

   bit clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst = 1'b1, en = 1'b0;
   logic [3:0]  sig_in = '0, clr_overrun = '0;
   logic [31:0] len_in = '0;
   logic [3:0]  ext_w [NC], dn_w [NC], ov_w [NC];

   for (genvar g = 0; g < NC; g++) begin : g_dut
      multi_channel_pulse_stretcher #(
         .CHANNELS   (4),
         .MAX_CYCLES (CM[g]),
         .RETRIGGER  (CR[g]),
         .EDGE_TRIG  (CE[g])
      ) u_dut (
         .clk         (clk),
         .rst         (rst),
         .en          (en),
         .sig_in      (sig_in),
         .len_in      (len_in),
         .clr_overrun (clr_overrun),
         .sig_ext     (ext_w[g]),
         .done        (dn_w[g]),
         .overrun     (ov_w[g])
      );
   end

   typedef struct packed {
      logic [NC-1:0][3:0] ext;
      logic [NC-1:0][3:0] dn;
      logic [NC-1:0][3:0] ov;
   } exp_t;

   exp_t q [$];
   int   checks = 0, errors = 0, cyc = 0;
   // Model: each channel remembers the last cycle its output is high.
   int   end_t [NC][4];
   bit   prv   [NC][4];
   bit   ovr   [NC][4];

   function automatic logic [31:0] rep(input logic [7:0] l);
      return {4{l}};
   endfunction

   task automatic step(input logic r, input logic e, input logic [3:0] s,
                       input logic [3:0] c, input logic [31:0] lv);
      exp_t x;
      int   l;
      bit   trig, act, drop;
      rst = r; en = e; sig_in = s; clr_overrun = c; len_in = lv;
      x = '0;
      for (int k = 0; k < NC; k++) begin
         for (int ch = 0; ch < 4; ch++) begin
            if (r) begin
               end_t[k][ch] = -1000;
               prv[k][ch]   = 1'b0;
               ovr[k][ch]   = 1'b0;
            end else begin
               trig = e && s[ch] && (CE[k] == 0 || !prv[k][ch]);
               prv[k][ch] = s[ch];
               l = int'(lv[ch*8 +: 8]);
               if (l > CM[k]) l = CM[k];
               act  = (end_t[k][ch] >= cyc);
               drop = 1'b0;
               if (trig && l > 0) begin
                  if (!act || CR[k] != 0 || end_t[k][ch] == cyc) end_t[k][ch] = cyc + l;
                  else drop = 1'b1;
               end
               ovr[k][ch] = drop || (ovr[k][ch] && !c[ch]);
            end
            x.ext[k][ch] = (end_t[k][ch] >= cyc + 1);
            x.dn[k][ch]  = !r && (end_t[k][ch] == cyc);
            x.ov[k][ch]  = ovr[k][ch];
         end
      end
      q.push_back(x);
      cyc++;
      @(negedge clk);
   endtask

   task automatic idle(input int n, input logic [31:0] lv);
      repeat (n) step(1'b0, 1'b1, 4'h0, 4'h0, lv);
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         checks++;
         if (q.size() == 0) begin
            errors++;
            $display("FAIL underflow: output cycle with no expected entry");
         end else begin
            e = q.pop_front();
            for (int g = 0; g < NC; g++) begin
               if ({ext_w[g], dn_w[g], ov_w[g]} !== {e.ext[g], e.dn[g], e.ov[g]}) begin
                  errors++;
                  $display("FAIL cfg%0d t=%0t ext/done/ovr got %b/%b/%b exp %b/%b/%b",
                           g, $time, ext_w[g], dn_w[g], ov_w[g], e.ext[g], e.dn[g], e.ov[g]);
               end
            end
         end
      end
   end

   initial begin : driver
      logic [3:0]  s;
      logic [31:0] lv;
      #1;
      step(1'b1, 1'b1, 4'h0, 4'h0, rep(7));
      step(1'b1, 1'b1, 4'h0, 4'h0, rep(7));
      // single edge, len 7
      step(1'b0, 1'b1, 4'h1, 4'h0, rep(7));
      idle(10, rep(7));
      // second edge 3 cycles into a len 5 pulse
      step(1'b0, 1'b1, 4'h1, 4'h0, rep(5));
      idle(2, rep(5));
      step(1'b0, 1'b1, 4'h1, 4'h0, rep(5));
      idle(10, rep(5));
      step(1'b0, 1'b1, 4'h0, 4'hF, rep(5));
      // drop coinciding with clear keeps the flag
      step(1'b0, 1'b1, 4'h3, 4'h0, rep(5));
      step(1'b0, 1'b1, 4'h0, 4'h0, rep(5));
      step(1'b0, 1'b1, 4'h3, 4'h3, rep(5));
      idle(8, rep(5));
      step(1'b0, 1'b1, 4'h0, 4'hF, rep(5));
      // zero length, clamp, and join at the last cycle
      step(1'b0, 1'b1, 4'hF, 4'h0, rep(0));
      idle(5, rep(0));
      step(1'b0, 1'b1, 4'h1, 4'h0, rep(250));
      idle(260, rep(250));
      step(1'b0, 1'b1, 4'h2, 4'h0, rep(4));
      idle(3, rep(4));
      step(1'b0, 1'b1, 4'h2, 4'h0, rep(4));
      idle(12, rep(4));
      // level held high, then enable low
      repeat (10) step(1'b0, 1'b1, 4'h4, 4'h0, rep(3));
      idle(6, rep(3));
      step(1'b0, 1'b1, 4'h8, 4'h0, rep(6));
      for (int i = 0; i < 12; i++) step(1'b0, 1'b0, (i % 2) ? 4'hF : 4'h0, 4'h0, rep(6));
      step(1'b0, 1'b1, 4'h0, 4'hF, rep(6));
      // reset mid-pulse with input held high
      step(1'b0, 1'b1, 4'h1, 4'h0, rep(10));
      step(1'b0, 1'b1, 4'h1, 4'h0, rep(10));
      step(1'b1, 1'b1, 4'h1, 4'h0, rep(10));
      repeat (14) step(1'b0, 1'b1, 4'h1, 4'h0, rep(10));
      idle(14, rep(10));
      // random traffic
      s = '0;
      repeat (2500) begin
         for (int ch = 0; ch < 4; ch++) begin
            if ($urandom_range(0, 4) == 0) s[ch] = ~s[ch];
            if ($urandom_range(0, 19) == 0) lv[ch*8 +: 8] = 8'($urandom_range(0, 255));
            else                            lv[ch*8 +: 8] = 8'($urandom_range(0, 12));
         end
         step($urandom_range(0, 299) == 0, $urandom_range(0, 7) != 0, s,
              ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15)) : 4'h0, lv);
      end
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d expected entries left, required 0", q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
